macc_issue_unit: RTL and testbench
==================================

# macc_issue_unit

Issue and writeback controller sitting directly upstream and downstream of the fixed-latency 64x64+128 multiply-accumulate DSP stage in the execute pipeline. It accepts multiply requests (MADD, MSUB, UMULH, MNEG) over a valid/ready handshake and drives the MACC operand ports. It tracks in-flight operations through a tag/op shift pipeline matched to MACC latency, selects the 64-bit result slice, and buffers results in an in-order FIFO with ready/valid backpressure. MACC enable is tied high and cannot stall, so admission is credit-based.

## Interface
- MACC_LATENCY, 3, cycles from operands on MACC inputs to result on `io_macc_res`
- FIFO_DEPTH, 8, result FIFO entries; must be ≥ 2
- TAG_W, 5, request tag width
- clock  input  1  sole clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- io_req_valid  input  1  request present
- io_req_ready  output  1  request accepted when valid && ready
- io_req_op  input  2  0=MADD, 1=MSUB, 2=UMULH, 3=MNEG
- io_req_a, io_req_b, io_req_c  input  64 each  operands
- io_req_tag  input  TAG_W  destination tag, returned unchanged
- io_macc_mult1, io_macc_mult2  output  64 each  to MACC multiplier inputs
- io_macc_add  output  128  to MACC addend
- io_macc_res  input  129  MACC result
- io_resp_valid  output  1  FIFO head valid
- io_resp_ready  input  1  consumer accepts head
- io_resp_data  output  64  result
- io_resp_tag  output  TAG_W  tag of result

## Operation
- Accept condition: `io_req_valid && io_req_ready`.
- Operand mapping is combinational from the request. Non-accept cycles drive zeros.
  - MADD: mult1=a, mult2=b, add={64'b0,c}, result=res[63:0].
  - MSUB: mult1=(~a+1) mod 2^64, mult2=b, add={64'b0,c}, result=res[63:0] (= c−a·b mod 2^64).
  - UMULH: mult1=a, mult2=b, add=0, result=res[127:64] (unsigned high product).
  - MNEG: mult1=(~a+1) mod 2^64, mult2=b, add=0, result=res[63:0].
  - res[128] is always ignored.
- Track pipe: MACC_LATENCY stages of {valid, op, tag}. Stage 0 is loaded on accept, and every stage shifts each cycle unconditionally.
- When the last stage is valid, the slice of `io_macc_res` selected by its op is written with its tag into the FIFO tail in the same cycle.
- FIFO: in-order, FIFO_DEPTH entries, head drives io_resp_*. Pop on `io_resp_valid && io_resp_ready`.
- Credit counter `used` (0..FIFO_DEPTH):
  - +1 on accept, −1 on pop, unchanged when both occur.
  - `io_req_ready = !reset && (used < FIFO_DEPTH)`.
  - This guarantees a FIFO write never finds the FIFO full.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH need not be a power of 2.

## Timing
- Reset values: `io_resp_valid`=0, `used`=0, all track-pipe valids=0, FIFO empty, `io_req_ready`=0 while reset is high and 1 in the first cycle after.
- Latency: request accepted in cycle t → FIFO write at end of cycle t+MACC_LATENCY → `io_resp_valid` earliest in cycle t+MACC_LATENCY+1. There is no bypass.
- Throughput: 1 per cycle while `io_resp_ready`=1 and FIFO_DEPTH ≥ MACC_LATENCY+2. Otherwise limited by credits.
- Simultaneous FIFO write and pop are both performed. With the FIFO empty, the written entry appears at the head the next cycle.
- Responses appear in acceptance order, and each tag is returned unchanged.
- Reset mid-operation clears all in-flight and buffered entries. MACC output in the following MACC_LATENCY cycles is discarded because all track valids are 0.
- `io_resp_data`/`io_resp_tag` are don't-care when `io_resp_valid`=0.

## Test plan
- MADD a=3, b=5, c=7, tag=1, resp_ready=1 → data=22, tag=1, resp_valid first high exactly MACC_LATENCY+1 cycles after accept.
- MSUB a=3, b=5, c=7 → 0xFFFF_FFFF_FFFF_FFF8. MNEG a=3, b=5 → 0xFFFF_FFFF_FFFF_FFF1.
- UMULH a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. UMULH a=2^32, b=2^32 → 1.
- Backpressure: resp_ready=0, 10 back-to-back requests with tags 0..9 → exactly 8 accepted and req_ready low after the 8th. Then resp_ready=1 → tags 0..7 drain in order, then tags 8 and 9 are accepted and returned.
- Full throughput: 20 back-to-back MADDs with resp_ready=1 → 20 responses on consecutive cycles, data=a·b+c for each.
- Reset asserted one cycle after 2 accepts → no response after reset deasserts, req_ready=1, and the next request returns correctly.

Source files
------------

// File: rtl/macc_issue_unit.sv
// Issue/writeback controller around a fixed-latency 64x64+128 MACC stage.
// Credit-based admission guarantees the result FIFO always has room for in-flight ops.
module macc_issue_unit #(
  parameter int MACC_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8,
  parameter int TAG_W        = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_req_valid,
  output logic               io_req_ready,
  input  logic [1:0]         io_req_op,
  input  logic [63:0]        io_req_a,
  input  logic [63:0]        io_req_b,
  input  logic [63:0]        io_req_c,
  input  logic [TAG_W-1:0]   io_req_tag,
  output logic [63:0]        io_macc_mult1,
  output logic [63:0]        io_macc_mult2,
  output logic [127:0]       io_macc_add,
  input  logic [128:0]       io_macc_res,
  output logic               io_resp_valid,
  input  logic               io_resp_ready,
  output logic [63:0]        io_resp_data,
  output logic [TAG_W-1:0]   io_resp_tag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] OP_MADD  = 2'd0;
  localparam logic [1:0] OP_MSUB  = 2'd1;
  localparam logic [1:0] OP_UMULH = 2'd2;
  localparam logic [1:0] OP_MNEG  = 2'd3;

  logic             accept;
  logic             pop;
  logic             push;
  logic [63:0]      neg_a;
  logic [63:0]      res_slice;
  logic             unused_res_msb;

  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [63:0]      fifo_data [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag  [FIFO_DEPTH];

  logic [MACC_LATENCY-1:0] trk_valid;
  logic [1:0]              trk_op  [MACC_LATENCY];
  logic [TAG_W-1:0]        trk_tag [MACC_LATENCY];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits count everything accepted but not yet popped, in flight or buffered.
  assign io_req_ready  = !reset && (used < CNT_W'(FIFO_DEPTH));
  assign accept        = io_req_valid && io_req_ready;
  assign io_resp_valid = (fifo_count != '0);
  assign pop           = io_resp_valid && io_resp_ready;
  assign push          = trk_valid[MACC_LATENCY-1];
  assign neg_a         = ~io_req_a + 64'd1;

  assign io_resp_data  = fifo_data[rd_ptr];
  assign io_resp_tag   = fifo_tag[rd_ptr];

  always_comb begin
    io_macc_mult1 = '0;
    io_macc_mult2 = '0;
    io_macc_add   = '0;
    if (accept) begin
      io_macc_mult2 = io_req_b;
      case (io_req_op)
        OP_MADD: begin
          io_macc_mult1 = io_req_a;
          io_macc_add   = {64'b0, io_req_c};
        end
        OP_MSUB: begin
          io_macc_mult1 = neg_a;
          io_macc_add   = {64'b0, io_req_c};
        end
        OP_UMULH: io_macc_mult1 = io_req_a;
        OP_MNEG:  io_macc_mult1 = neg_a;
        default:  io_macc_mult1 = io_req_a;
      endcase
    end
  end

  assign res_slice = (trk_op[MACC_LATENCY-1] == OP_UMULH) ? io_macc_res[127:64]
                                                          : io_macc_res[63:0];
  assign unused_res_msb = io_macc_res[128];

  always_ff @(posedge clock) begin
    if (reset) begin
      trk_valid <= '0;
    end else begin
      trk_valid[0] <= accept;
      for (int i = 1; i < MACC_LATENCY; i++) begin
        trk_valid[i] <= trk_valid[i-1];
      end
    end
  end

  // Op/tag ride alongside the valid bit; they only matter where valid is set.
  always_ff @(posedge clock) begin
    trk_op[0]  <= io_req_op;
    trk_tag[0] <= io_req_tag;
    for (int i = 1; i < MACC_LATENCY; i++) begin
      trk_op[i]  <= trk_op[i-1];
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      used <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   used <= used + CNT_W'(1);
        2'b01:   used <= used - CNT_W'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifo_data[wr_ptr] <= res_slice;
      fifo_tag[wr_ptr]  <= trk_tag[MACC_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_macc_issue_unit.sv
// Directed bench for macc_issue_unit with a behavioural 3-cycle MACC attached.
module tb_macc_issue_unit;
  localparam int L  = 3;
  localparam int D  = 8;
  localparam int TW = 5;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           io_req_valid = 1'b0;
  logic           io_req_ready;
  logic [1:0]     io_req_op = 2'd0;
  logic [63:0]    io_req_a = '0;
  logic [63:0]    io_req_b = '0;
  logic [63:0]    io_req_c = '0;
  logic [TW-1:0]  io_req_tag = '0;
  logic [63:0]    io_macc_mult1;
  logic [63:0]    io_macc_mult2;
  logic [127:0]   io_macc_add;
  logic [128:0]   io_macc_res;
  logic           io_resp_valid;
  logic           io_resp_ready = 1'b1;
  logic [63:0]    io_resp_data;
  logic [TW-1:0]  io_resp_tag;

  int total = 0;
  int bad   = 0;

  macc_issue_unit #(.MACC_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_op(io_req_op), .io_req_a(io_req_a), .io_req_b(io_req_b),
    .io_req_c(io_req_c), .io_req_tag(io_req_tag),
    .io_macc_mult1(io_macc_mult1), .io_macc_mult2(io_macc_mult2),
    .io_macc_add(io_macc_add), .io_macc_res(io_macc_res),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_tag(io_resp_tag)
  );

  always #5 clock = ~clock;

  // External MACC: operands in cycle t, result visible in cycle t+3.
  logic [128:0] p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clock) begin
    p0 <= {65'b0, io_macc_mult1} * {65'b0, io_macc_mult2} + {1'b0, io_macc_add};
    p1 <= p0;
    p2 <= p1;
  end
  assign io_macc_res = p2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_req_valid = 1'b1;
    tick();
    tick();
    total++;
    if (io_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%0b want=0", io_req_ready);
    end
    total++;
    if (io_resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_resp_valid got=%0b want=0", io_resp_valid);
    end
    io_req_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (io_req_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_ready got=%0b want=1", io_req_ready);
    end
    tick();
  endtask

  task automatic test_single(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] c, input logic [TW-1:0] tag,
                             input logic [63:0] exp_m1, input logic [127:0] exp_add,
                             input logic [63:0] exp, input string name);
    int k;
    io_resp_ready = 1'b1;
    io_req_valid = 1'b1;
    io_req_op = op; io_req_a = a; io_req_b = b; io_req_c = c; io_req_tag = tag;
    #1;
    total++;
    if (io_req_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%0b want=1", name, io_req_ready);
    end
    total++;
    if (io_macc_mult1 !== exp_m1 || io_macc_mult2 !== b || io_macc_add !== exp_add) begin
      bad++; $display("FAIL %s_operands got m1=%h m2=%h add=%h want m1=%h m2=%h add=%h",
                      name, io_macc_mult1, io_macc_mult2, io_macc_add, exp_m1, b, exp_add);
    end
    tick();
    io_req_valid = 1'b0;
    #1;
    total++;
    if (io_macc_mult1 !== 64'd0 || io_macc_mult2 !== 64'd0 || io_macc_add !== 128'd0) begin
      bad++; $display("FAIL %s_idle_zero got m1=%h m2=%h add=%h want all 0",
                      name, io_macc_mult1, io_macc_mult2, io_macc_add);
    end
    k = 1;
    while (!io_resp_valid && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (k != L + 1) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, k, L + 1);
    end
    total++;
    if (io_resp_data !== exp || io_resp_tag !== tag) begin
      bad++; $display("FAIL %s_result got data=%h tag=%0d want data=%h tag=%0d",
                      name, io_resp_data, io_resp_tag, exp, tag);
    end
    tick();
    total++;
    if (io_resp_valid !== 1'b0) begin
      bad++; $display("FAIL %s_popped got=%0b want=0", name, io_resp_valid);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int got;
    logic [63:0] exp;
    idx = 0;
    io_resp_ready = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      io_req_valid = (idx < 10);
      io_req_op = 2'd0; io_req_a = 64'(idx); io_req_b = 64'd2; io_req_c = 64'd1;
      io_req_tag = TW'(idx);
      #1;
      if (io_req_valid && io_req_ready) idx++;
      tick();
    end
    #1;
    total++;
    if (idx != 8) begin
      bad++; $display("FAIL bp_accepted got=%0d want=8", idx);
    end
    total++;
    if (io_req_ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_low got=%0b want=0", io_req_ready);
    end
    io_resp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      io_req_valid = (idx < 10);
      io_req_a = 64'(idx); io_req_tag = TW'(idx);
      #1;
      if (io_resp_valid) begin
        exp = 64'(got) * 64'd2 + 64'd1;
        total++;
        if (io_resp_tag !== TW'(got) || io_resp_data !== exp) begin
          bad++; $display("FAIL bp_drain got tag=%0d data=%h want tag=%0d data=%h",
                          io_resp_tag, io_resp_data, got, exp);
        end
        got++;
      end
      if (io_req_valid && io_req_ready) idx++;
      tick();
    end
    io_req_valid = 1'b0;
    total++;
    if (got != 10 || idx != 10) begin
      bad++; $display("FAIL bp_complete got resp=%0d acc=%0d want resp=10 acc=10", got, idx);
    end
  endtask

  task automatic test_back_to_back();
    int sent, got, first, last, stalls;
    logic [63:0] exp;
    sent = 0; got = 0; first = -1; last = -1; stalls = 0;
    io_resp_ready = 1'b1;
    io_req_op = 2'd0;
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      io_req_valid = (sent < 20);
      io_req_a = 64'(sent + 1); io_req_b = 64'(sent + 3); io_req_c = 64'(100 * sent);
      io_req_tag = TW'(sent);
      #1;
      if (io_req_valid && !io_req_ready) stalls++;
      if (io_resp_valid) begin
        exp = 64'(got + 1) * 64'(got + 3) + 64'(100 * got);
        total++;
        if (io_resp_tag !== TW'(got) || io_resp_data !== exp) begin
          bad++; $display("FAIL b2b_data got tag=%0d data=%h want tag=%0d data=%h",
                          io_resp_tag, io_resp_data, got, exp);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (io_req_valid && io_req_ready) sent++;
      tick();
    end
    io_req_valid = 1'b0;
    total++;
    if (got != 20 || last - first != 19) begin
      bad++; $display("FAIL b2b_consecutive got resp=%0d span=%0d want resp=20 span=19",
                      got, last - first);
    end
    total++;
    if (stalls != 0) begin
      bad++; $display("FAIL b2b_stalls got=%0d want=0", stalls);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    io_resp_ready = 1'b1;
    io_req_valid = 1'b1;
    io_req_op = 2'd0; io_req_a = 64'd4; io_req_b = 64'd4; io_req_c = 64'd4;
    io_req_tag = TW'(3);
    tick();
    io_req_tag = TW'(4);
    tick();
    io_req_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (io_req_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_ready got=%0b want=0", io_req_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (io_req_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_ready_after got=%0b want=1", io_req_ready);
    end
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (io_resp_valid) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midrst_no_resp got=%0d want=0", seen);
    end
    test_single(2'd0, 64'd10, 64'd20, 64'd30, TW'(9), 64'd10, 128'd30, 64'd230, "midrst_next");
  endtask

  initial begin
    test_reset();
    test_single(2'd0, 64'd3, 64'd5, 64'd7, TW'(1), 64'd3, 128'd7, 64'd22, "madd");
    test_single(2'd1, 64'd3, 64'd5, 64'd7, TW'(2), 64'hFFFF_FFFF_FFFF_FFFD, 128'd7,
                64'hFFFF_FFFF_FFFF_FFF8, "msub");
    test_single(2'd3, 64'd3, 64'd5, 64'd7, TW'(3), 64'hFFFF_FFFF_FFFF_FFFD, 128'd0,
                64'hFFFF_FFFF_FFFF_FFF1, "mneg");
    test_single(2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, TW'(4),
                64'hFFFF_FFFF_FFFF_FFFF, 128'd0, 64'hFFFF_FFFF_FFFF_FFFE, "umulh_max");
    test_single(2'd2, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, TW'(31),
                64'h1_0000_0000, 128'd0, 64'd1, "umulh_2p32");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
